sw_debounce8: RTL and testbench
===============================

# sw_debounce8

Input conditioning stage for the slide-switch bank. Synchronises an asynchronous 8-bit switch vector into the `clk` domain and debounces each bit independently with a per-bit stability counter. Emits a clean level vector plus single-cycle rise/fall/changed strobes. `out_stable` connects directly to the `in[7:0]` port of the 8-to-3 priority encoder / seven-segment stage, so the encoder and display never see bounce or metastable values.

## Interface
- `WIDTH`, 8: number of independent switch channels.
- `CNT_W`, 16: width of each per-bit stability counter.
- `STABLE_CYCLES`, 50000: consecutive cycles a synchronised bit must differ from `out_stable` before the output flips (1 ms at 50 MHz).
  - Legal range is 1 to 2^CNT_W − 1.
  - Benches override it with a small value.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `resetn` input 1: asynchronous, active-low reset; assertion is asynchronous, deassertion is sampled by `clk`.
- `in_raw` input WIDTH: raw switch levels, asynchronous to `clk`.
- `out_stable` output WIDTH: debounced level per bit; feeds the encoder `in`.
- `rise` output WIDTH: one-cycle pulse on the edge where `out_stable[i]` goes 0→1.
- `fall` output WIDTH: one-cycle pulse on the edge where `out_stable[i]` goes 1→0.
- `changed` output 1: one-cycle pulse, high iff any bit of `rise` or `fall` is high in the same cycle.

## Operation
- **Synchroniser.** Two flops per bit: `s1 <= in_raw`, then `s2 <= s1`. Only `s2` is used downstream.
- **Per-bit state.** Each bit i has a counter `c[i]` (CNT_W bits) and a stable bit `out_stable[i]`. No cross-bit coupling.
- **Rules at each edge, per bit:**
  - If `s2[i] == out_stable[i]`: `c[i] <= 0`; the bit is idle. A glitch shorter than the threshold is discarded this way.
  - If they differ and `c[i] == STABLE_CYCLES−1`: `out_stable[i] <= s2[i]`, `c[i] <= 0`, and the matching `rise[i]` or `fall[i]` is set for this one cycle.
  - If they differ otherwise: `c[i] <= c[i]+1`.
- **Strobes.**
  - `rise`, `fall` and `changed` are registered and default to 0 every cycle unless set by the flip rule.
  - `rise[i]` and `fall[i]` are never high together.
- **Counter range.** The counter never exceeds STABLE_CYCLES−1, so it cannot wrap.
- **Simultaneous flips.** Several bits may flip on the same edge. Their `rise`/`fall` bits are all set and `changed` is a single pulse.
- **Reset.** `resetn` low asynchronously clears `s1`, `s2`, every `c[i]`, `out_stable`, `rise`, `fall` and `changed` to 0.
  - Reset mid-count discards the partial count.
  - A switch held high through reset produces a normal `rise` after the full latency once reset is released.

## Timing
- **Latency.** Let `in_raw[i]` change before edge k and then stay constant.
  - `s1` captures it at edge k; `s2` captures it at edge k+1.
  - `out_stable[i]` and the strobe update at edge k+1+STABLE_CYCLES.
  - With STABLE_CYCLES=1 this is edge k+2.
- **Strobe width.** Each strobe is high for exactly one cycle and aligns with the cycle in which `out_stable` first shows the new value.
- **Bounce.** Any `s2` sample equal to `out_stable` restarts the count. A new level must hold in `s2` for STABLE_CYCLES consecutive edges to be accepted.
- **No combinational paths.** No path runs from input to output; every output is a flop.
- **Reset values.** All outputs read 0 while `resetn` is low and in the first cycle after release.

## Test plan
Run with STABLE_CYCLES=4, CNT_W=4.

1. **Reset with input high.** Hold `resetn`=0 with `in_raw`=8'hFF. Expect all outputs 0. Release before edge 0. Expect `out_stable`=8'hFF, `rise`=8'hFF and `changed`=1 after edge 5, and all strobes 0 after edge 6.
2. **Clean single rise.** From reset-idle 0, set `in_raw`=8'h80 before edge k. Expect `out_stable`=8'h80, `rise`=8'h80 and `changed`=1 after edge k+5, and no other strobe pulses.
3. **Bounce rejected.** Toggle `in_raw[3]` 1,1,1,0,1,1,1,1 across consecutive edges. Expect the count to restart at the 0, so `out_stable[3]` rises exactly 4 `s2`-stable edges after the last 0 reached `s2`. Expect exactly one `rise[3]` pulse.
4. **Short glitch ignored.** With `out_stable`=8'h01, pulse `in_raw[0]` low for 3 cycles. Expect `out_stable` to stay 8'h01 and `fall` and `changed` to stay 0 throughout.
5. **Simultaneous multi-bit events.** Change `in_raw` from 8'h0F to 8'hF0 in one cycle. Expect `rise`=8'hF0, `fall`=8'h0F and a single `changed` pulse on the same edge, with `out_stable`=8'hF0.
6. **Reset mid-count.** Set `in_raw`=8'h02, then assert `resetn` low asynchronously 3 edges later. Expect outputs to clear immediately with no strobe. After release, expect the full latency from scratch before `rise[1]`.

Source files
------------

// File: rtl/sw_debounce8.sv
// sw_debounce8
//
// Input conditioning for the slide-switch bank. The asynchronous switch
// vector passes through a two-flop synchroniser into the clk domain. Each
// bit is then debounced on its own by a stability counter. A bit of
// out_stable flips only after the synchronised level has differed from it
// for STABLE_CYCLES consecutive edges. On the edge where a bit flips, a
// single-cycle rise/fall strobe is raised for that bit, and a single-cycle
// changed strobe is raised if any bit flipped.
//
// Parameters
//   WIDTH          number of independent switch channels
//   CNT_W          width of each per-bit stability counter
//   STABLE_CYCLES  consecutive differing samples needed to accept a new level
//                  (legal range 1 .. 2**CNT_W-1)
//
// Ports
//   clk         in   single clock, rising edge
//   resetn      in   asynchronous active-low reset
//   in_raw      in   raw switch levels, asynchronous to clk
//   out_stable  out  debounced level per bit (feeds the priority encoder)
//   rise        out  one-cycle pulse when out_stable[i] goes 0->1
//   fall        out  one-cycle pulse when out_stable[i] goes 1->0
//   changed     out  one-cycle pulse when any rise/fall bit is high
//
// Every output comes straight from a flop, so no path runs from in_raw to
// an output without passing through a register.

module sw_debounce8 #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned STABLE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] in_raw,
    output logic [WIDTH-1:0] out_stable,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    // Terminal count. The counter sits at this value on the last differing
    // sample before the flip, so it never passes STABLE_CYCLES-1 and cannot
    // wrap.
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(STABLE_CYCLES - 1);

    // Synchroniser. Only sync2_q is used downstream.
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    // Per-bit debounce state
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] stable_q, stable_d;

    // Registered strobes
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;

        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                // Level agrees with the output. Any partial count belonged
                // to a glitch and is discarded.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_TC) begin
                // Level has differed for STABLE_CYCLES consecutive edges.
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
                if (sync2_q[i]) begin
                    rise_d[i] = 1'b1;
                end else begin
                    fall_d[i] = 1'b1;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end

        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= in_raw;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign out_stable = stable_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign changed    = changed_q;

endmodule

// File: tb/tb_sw_debounce8.sv
// Testbench for sw_debounce8 with STABLE_CYCLES=4 and CNT_W=4.
// A directed vector table covers reset, clean edges, glitch rejection and
// simultaneous flips. Hand-written sequences cover bounce and reset
// mid-count. A randomized phase is checked against a run-length reference
// model.

module tb_sw_debounce8;

    localparam int STABLE = 4;

    logic       clk;
    logic       resetn;
    logic [7:0] in_raw;
    logic [7:0] out_stable, rise, fall;
    logic       changed;

    int n_tests = 0;
    int n_fail  = 0;

    sw_debounce8 #(
        .WIDTH        (8),
        .CNT_W        (4),
        .STABLE_CYCLES(STABLE)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_raw    (in_raw),
        .out_stable(out_stable),
        .rise      (rise),
        .fall      (fall),
        .changed   (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The reference model works on input runs. For each bit it counts how
    // many consecutive edges the synchronised level has held its current
    // value. The output takes that level once the run reaches STABLE, as
    // long as the level differs from the output.
    typedef struct packed {
        logic [7:0]      out;
        logic [7:0]      rise;
        logic [7:0]      fall;
        logic [7:0]      prev;
        logic [7:0][7:0] run;
    } mstate_t;

    mstate_t    m_st;
    logic [7:0] m_p1, m_p2;

    function automatic mstate_t model_next(mstate_t cur, logic [7:0] s2);
        mstate_t n = cur;
        n.rise = '0;
        n.fall = '0;
        for (int i = 0; i < 8; i++) begin
            if (s2[i] == cur.prev[i]) begin
                if (cur.run[i] < 8'd255) n.run[i] = cur.run[i] + 8'd1;
            end else begin
                n.run[i] = 8'd1;
            end
            n.prev[i] = s2[i];
            if (s2[i] != cur.out[i] && int'(n.run[i]) >= STABLE) begin
                n.out[i] = s2[i];
                if (s2[i]) n.rise[i] = 1'b1;
                else       n.fall[i] = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_st <= '0;
            m_p1 <= '0;
            m_p2 <= '0;
        end else begin
            m_st <= model_next(m_st, m_p2);
            m_p2 <= m_p1;
            m_p1 <= in_raw;
        end
    end

    task automatic check_vec(input string name, input logic [24:0] act, input logic [24:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got out=%h rise=%h fall=%h chg=%b, expected out=%h rise=%h fall=%h chg=%b",
                     name, act[24:17], act[16:9], act[8:1], act[0],
                     exp[24:17], exp[16:9], exp[8:1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string name);
        check_vec(name, {out_stable, rise, fall, changed},
                  {m_st.out, m_st.rise, m_st.fall, |(m_st.rise | m_st.fall)});
    endtask

    // Called at a negedge. Drives the input, lets one rising edge pass, and
    // checks at the following negedge.
    task automatic step(input logic [7:0] v, input string name);
        in_raw = v;
        @(posedge clk);
        @(negedge clk);
        check_model(name);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_vec("reset_hold", {out_stable, rise, fall, changed}, 25'd0);
        resetn = 1'b1;
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] in;
        logic [7:0] out;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       chg;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic [7:0] i, input logic [7:0] o,
                       input logic [7:0] rs, input logic [7:0] fl, input logic c);
        vec_t v;
        v.rst = r; v.in = i; v.out = o; v.rise = rs; v.fall = fl; v.chg = c;
        tv.push_back(v);
    endtask

    task automatic add_hold(input logic [7:0] i, input logic [7:0] o, input int n);
        for (int k = 0; k < n; k++) add(1'b0, i, o, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        logic [0:7] pat;
        logic [7:0] v;
        int         pulses, pos;

        resetn = 1'b0;
        in_raw = 8'h00;

        // Reset with the input high, then a rise after the full latency.
        add(1'b1, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
        add_hold(8'hFF, 8'h00, 5);
        add(1'b0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b1);
        add_hold(8'hFF, 8'hFF, 1);
        // Clean single rise from an idle 0.
        add(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        add_hold(8'h00, 8'h00, 1);
        add_hold(8'h80, 8'h00, 5);
        add(1'b0, 8'h80, 8'h80, 8'h80, 8'h00, 1'b1);
        add_hold(8'h80, 8'h80, 1);
        // Move to 01 (one bit rises and one falls on the same edge).
        add_hold(8'h01, 8'h80, 5);
        add(1'b0, 8'h01, 8'h01, 8'h01, 8'h80, 1'b1);
        add_hold(8'h01, 8'h01, 1);
        // A 3-cycle low glitch on bit 0 is ignored.
        add_hold(8'h00, 8'h01, 3);
        add_hold(8'h01, 8'h01, 6);
        // Move to 0F, then 0F -> F0 in one cycle.
        add_hold(8'h0F, 8'h01, 5);
        add(1'b0, 8'h0F, 8'h0F, 8'h0E, 8'h00, 1'b1);
        add_hold(8'h0F, 8'h0F, 1);
        add_hold(8'hF0, 8'h0F, 5);
        add(1'b0, 8'hF0, 8'hF0, 8'hF0, 8'h0F, 1'b1);
        add_hold(8'hF0, 8'hF0, 1);

        @(negedge clk);
        for (int r = 0; r < tv.size(); r++) begin
            resetn = !tv[r].rst;
            in_raw = tv[r].in;
            @(posedge clk);
            @(negedge clk);
            check_vec($sformatf("vec%0d", r), {out_stable, rise, fall, changed},
                      {tv[r].out, tv[r].rise, tv[r].fall, tv[r].chg});
            check_model($sformatf("vec%0d_model", r));
        end

        // Bounce on bit 3: 1,1,1,0 then steady 1. The rise must come four
        // stable edges after the 0 leaves s2, which is edge k+9.
        in_raw = 8'h00;
        do_reset();
        pat = 8'b1110_1111;
        pulses = 0;
        pos = -1;
        for (int j = 0; j < 20; j++) begin
            v = 8'h00;
            v[3] = (j < 8) ? pat[j] : 1'b1;
            step(v, $sformatf("bounce%0d", j));
            if (rise[3]) begin
                pulses++;
                pos = j;
            end
        end
        check_int("bounce_rise_pulses", pulses, 1);
        check_int("bounce_rise_edge", pos, 9);
        check_int("bounce_out_bit3", int'(out_stable[3]), 1);

        // Reset three edges into a count on bit 1. Bit 3 is already high,
        // so clearing the outputs is visible at once.
        for (int j = 0; j < 3; j++) step(8'h0A, $sformatf("midcnt%0d", j));
        #2 resetn = 1'b0;
        #1 check_vec("async_clear", {out_stable, rise, fall, changed}, 25'd0);
        @(negedge clk);
        check_vec("async_clear_hold", {out_stable, rise, fall, changed}, 25'd0);
        resetn = 1'b1;
        pulses = 0;
        pos = -1;
        for (int j = 0; j < 10; j++) begin
            step(8'h0A, $sformatf("after_rst%0d", j));
            if (rise[1]) begin
                pulses++;
                pos = j;
            end
        end
        check_int("rst_midcnt_pulses", pulses, 1);
        check_int("rst_midcnt_edge", pos, 5);

        // Randomized bouncy stimulus against the model.
        do_reset();
        v = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 5) == 0) v[b] = ~v[b];
            end
            if ($urandom_range(0, 399) == 0) begin
                in_raw = v;
                do_reset();
            end else begin
                step(v, $sformatf("rand%0d", c));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
